// File: rtl/parametric_tensor_core.sv
// Parametrised DIMxDIM tensor core: one result element per clock, row-major,
// over operands snapshotted at the accept edge, with optional saturation.
module parametric_tensor_core #(
   parameter int DATA_WIDTH = 8,
   parameter int DIM        = 3,
   parameter bit SATURATE   = 1'b1
) (
   input  logic                         clock_in,
   input  logic                         reset_n_in,
   input  logic                         start_in,
   input  logic [2:0]                   operation_select_in,
   input  logic signed [DATA_WIDTH-1:0] tensor_core_input1 [DIM][DIM],
   input  logic signed [DATA_WIDTH-1:0] tensor_core_input2 [DIM][DIM],
   output logic signed [DATA_WIDTH-1:0] tensor_core_output [DIM][DIM],
   output logic                         busy_out,
   output logic                         done_out,
   output logic                         error_out
);

   localparam int PW = 2 * DATA_WIDTH;
   localparam int SW = PW + $clog2(DIM);
   localparam int MW = SW + 1;
   localparam int RW = $clog2(DIM);

   localparam logic signed [MW-1:0] MAX_V = {{(MW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [MW-1:0] MIN_V = {{(MW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

   typedef enum logic {
      S_IDLE,
      S_COMPUTE
   } state_t;

   typedef enum logic [2:0] {
      OP_MUL  = 3'b000,
      OP_ADD  = 3'b001,
      OP_RELU = 3'b010,
      OP_SUB  = 3'b011,
      OP_MAC  = 3'b100
   } op_t;

   state_t state_q, state_d;

   logic [RW-1:0]                 row_q, col_q;
   logic [2:0]                    op_q;
   logic signed [DATA_WIDTH-1:0]  a_q   [DIM][DIM];
   logic signed [DATA_WIDTH-1:0]  b_q   [DIM][DIM];
   logic signed [DATA_WIDTH-1:0]  out_q [DIM][DIM];
   logic                          done_q, err_q;

   logic                          last_elem;
   logic                          op_valid;
   logic signed [PW-1:0]          prod;
   logic signed [MW-1:0]          acc, res, a_ext, b_ext, o_ext;
   logic signed [DATA_WIDTH-1:0]  elem;

   assign last_elem = (row_q == RW'(DIM-1)) && (col_q == RW'(DIM-1));
   assign op_valid  = (op_q <= 3'd4);

   always_ff @(posedge clock_in or negedge reset_n_in) begin
      if (!reset_n_in) state_q <= S_IDLE;
      else             state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      busy_out = 1'b0;
      case (state_q)
         S_IDLE:    if (start_in) state_d = S_COMPUTE;
         S_COMPUTE: begin
            busy_out = 1'b1;
            if (last_elem) state_d = S_IDLE;
         end
         default:   state_d = S_IDLE;
      endcase
   end

   // Full-precision element result; mul sum is wide enough that it cannot overflow.
   always_comb begin
      prod  = '0;
      acc   = '0;
      a_ext = {{(MW-DATA_WIDTH){a_q[row_q][col_q][DATA_WIDTH-1]}}, a_q[row_q][col_q]};
      b_ext = {{(MW-DATA_WIDTH){b_q[row_q][col_q][DATA_WIDTH-1]}}, b_q[row_q][col_q]};
      o_ext = {{(MW-DATA_WIDTH){out_q[row_q][col_q][DATA_WIDTH-1]}}, out_q[row_q][col_q]};
      for (int unsigned k = 0; k < DIM; k++) begin
         prod = a_q[row_q][k] * b_q[k][col_q];
         acc  = acc + {{(MW-PW){prod[PW-1]}}, prod};
      end
      case (op_q)
         OP_MUL:  res = acc;
         OP_ADD:  res = a_ext + b_ext;
         OP_RELU: res = a_ext[MW-1] ? '0 : a_ext;
         OP_SUB:  res = a_ext - b_ext;
         OP_MAC:  res = acc + o_ext;
         default: res = '0;
      endcase
      if (SATURATE) begin
         if (res > MAX_V)      elem = MAX_V[DATA_WIDTH-1:0];
         else if (res < MIN_V) elem = MIN_V[DATA_WIDTH-1:0];
         else                  elem = res[DATA_WIDTH-1:0];
      end else begin
         elem = res[DATA_WIDTH-1:0];
      end
   end

   always_ff @(posedge clock_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         for (int unsigned i = 0; i < DIM; i++) begin
            for (int unsigned j = 0; j < DIM; j++) begin
               a_q[i][j]   <= '0;
               b_q[i][j]   <= '0;
               out_q[i][j] <= '0;
            end
         end
         row_q  <= '0;
         col_q  <= '0;
         op_q   <= '0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start_in) begin
                  op_q  <= operation_select_in;
                  a_q   <= tensor_core_input1;
                  b_q   <= tensor_core_input2;
                  row_q <= '0;
                  col_q <= '0;
                  err_q <= (operation_select_in > 3'd4);
               end
            end
            S_COMPUTE: begin
               if (op_valid) out_q[row_q][col_q] <= elem;
               if (col_q == RW'(DIM-1)) begin
                  col_q <= '0;
                  row_q <= row_q + 1'b1;
               end else begin
                  col_q <= col_q + 1'b1;
               end
               if (last_elem) done_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign tensor_core_output = out_q;
   assign done_out           = done_q;
   assign error_out          = err_q;

endmodule

// File: tb/tb_parametric_tensor_core.sv
// Directed bench for parametric_tensor_core: saturating and wrapping 8-bit 3x3
// instances driven in parallel, expected matrices written out by hand.
module tb_parametric_tensor_core;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic [2:0]        op_sel;
   logic signed [7:0] a_in  [3][3];
   logic signed [7:0] b_in  [3][3];
   logic signed [7:0] out_s [3][3];
   logic signed [7:0] out_w [3][3];
   logic signed [7:0] exp_m [3][3];
   logic              busy_s, done_s, err_s;
   logic              busy_w, done_w, err_w;
   int                checks;
   int                failures;

   parametric_tensor_core #(.DATA_WIDTH(8), .DIM(3), .SATURATE(1'b1)) u_sat (
      .clock_in            (clk),
      .reset_n_in          (rst_n),
      .start_in            (start),
      .operation_select_in (op_sel),
      .tensor_core_input1  (a_in),
      .tensor_core_input2  (b_in),
      .tensor_core_output  (out_s),
      .busy_out            (busy_s),
      .done_out            (done_s),
      .error_out           (err_s)
   );

   parametric_tensor_core #(.DATA_WIDTH(8), .DIM(3), .SATURATE(1'b0)) u_wrap (
      .clock_in            (clk),
      .reset_n_in          (rst_n),
      .start_in            (start),
      .operation_select_in (op_sel),
      .tensor_core_input1  (a_in),
      .tensor_core_input2  (b_in),
      .tensor_core_output  (out_w),
      .busy_out            (busy_w),
      .done_out            (done_w),
      .error_out           (err_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int expv);
      checks++;
      if (got != expv) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, expv);
      end
   endtask

   task automatic check_mat(input string tag, input logic wrap);
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            check(tag, wrap ? int'(out_w[i][j]) : int'(out_s[i][j]), int'(exp_m[i][j]));
   endtask

   task automatic set_all(input int va, input int vb);
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++) begin
            a_in[i][j] = 8'(va);
            b_in[i][j] = 8'(vb);
         end
   endtask

   task automatic set_exp(input int v);
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            exp_m[i][j] = 8'(v);
   endtask

   task automatic set_ident_a();
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            a_in[i][j] = (i == j) ? 8'sd1 : 8'sd0;
   endtask

   task automatic set_seq_b();
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            b_in[i][j] = 8'(i*3 + j + 1);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench 1 time unit into the done cycle, start low.
   task automatic run_op(input logic [2:0] op);
      int   n;
      logic exp_err;
      exp_err = (op > 3'd4);
      op_sel  = op;
      start   = 1'b1;
      step();
      start   = 1'b0;
      check("err_accept", int'(err_s), int'(exp_err));
      check("err_accept_wrap", int'(err_w), int'(exp_err));
      n = 0;
      while (!done_s && n < 20) begin
         check("busy_compute", int'(busy_s), 1);
         step();
         n++;
      end
      check("latency", n, 9);
      check("busy_in_done", int'(busy_s), 0);
      check("done_wrap", int'(done_w), 1);
      check("busy_wrap", int'(busy_w), 0);
      check("err_hold", int'(err_s), int'(exp_err));
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      start    = 1'b0;
      op_sel   = 3'b000;
      rst_n    = 1'b1;
      set_all(0, 0);
      set_exp(0);
      #2 rst_n = 1'b0;
      #6;
      check_mat("reset_out", 1'b0);
      check("reset_busy", int'(busy_s), 0);
      check("reset_done", int'(done_s), 0);
      check("reset_err", int'(err_s), 0);
      #4 rst_n = 1'b1;
      step();

      // identity * [1..9]
      set_ident_a();
      set_seq_b();
      run_op(3'b000);
      exp_m = b_in;
      check_mat("t1_mul", 1'b0);
      check_mat("t1_mul_wrap", 1'b1);
      check("t1_err", int'(err_s), 0);
      step();
      check("t1_done_pulse_end", int'(done_s), 0);
      check("t1_busy_idle", int'(busy_s), 0);

      // saturation versus wrap on large dot products
      set_all(127, 127);
      run_op(3'b000);
      set_exp(127);
      check_mat("t2_mul_sat", 1'b0);
      set_exp(3);
      check_mat("t2_mul_wrap", 1'b1);
      set_all(-128, 127);
      run_op(3'b000);
      set_exp(-128);
      check_mat("t2_mul_neg_sat", 1'b0);
      check_mat("t2_mul_neg_wrap", 1'b1);

      // add / sub / relu
      set_all(100, 100);
      run_op(3'b001);
      set_exp(127);
      check_mat("t3_add_sat", 1'b0);
      set_exp(-56);
      check_mat("t3_add_wrap", 1'b1);
      set_all(-100, 100);
      run_op(3'b011);
      set_exp(-128);
      check_mat("t3_sub_sat", 1'b0);
      set_exp(56);
      check_mat("t3_sub_wrap", 1'b1);
      a_in[0][0] = -8'sd5;  a_in[0][1] = 8'sd0;   a_in[0][2] = 8'sd7;
      a_in[1][0] = 8'sd1;   a_in[1][1] = -8'sd1;  a_in[1][2] = -8'sd128;
      a_in[2][0] = 8'sd127; a_in[2][1] = 8'sd3;   a_in[2][2] = -8'sd2;
      run_op(3'b010);
      exp_m[0][0] = 8'sd0;   exp_m[0][1] = 8'sd0; exp_m[0][2] = 8'sd7;
      exp_m[1][0] = 8'sd1;   exp_m[1][1] = 8'sd0; exp_m[1][2] = 8'sd0;
      exp_m[2][0] = 8'sd127; exp_m[2][1] = 8'sd3; exp_m[2][2] = 8'sd0;
      check_mat("t3_relu", 1'b0);
      check_mat("t3_relu_wrap", 1'b1);

      // mac from reset, second start issued in the done cycle
      #2 rst_n = 1'b0;
      #1;
      set_exp(0);
      check_mat("t4_reset_out", 1'b0);
      #2 rst_n = 1'b1;
      set_all(0, 2);
      set_ident_a();
      run_op(3'b100);
      set_exp(2);
      check_mat("t4_mac1", 1'b0);
      run_op(3'b100);
      set_exp(4);
      check_mat("t4_mac2", 1'b0);
      step();

      // operand snapshot and start-while-busy
      set_ident_a();
      set_seq_b();
      exp_m = b_in;
      begin
         int n;
         op_sel = 3'b000;
         start  = 1'b1;
         step();
         start = 1'b0;
         step();
         step();
         set_all(127, -1);
         op_sel = 3'b001;
         start  = 1'b1;
         step();
         start = 1'b0;
         n = 3;
         check("t5_busy_after_restart", int'(busy_s), 1);
         while (!done_s && n < 20) begin
            step();
            n++;
         end
         check("t5_latency", n, 9);
      end
      check_mat("t5_snapshot", 1'b0);
      step();
      check("t5_no_second_run", int'(busy_s), 0);

      // reset mid-operation, then invalid op, then a valid op clears error
      set_ident_a();
      set_seq_b();
      op_sel = 3'b000;
      start  = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 4; i++) step();
      #2 rst_n = 1'b0;
      #1;
      set_exp(0);
      check_mat("t6_reset_out", 1'b0);
      check_mat("t6_reset_out_wrap", 1'b1);
      check("t6_reset_busy", int'(busy_s), 0);
      check("t6_reset_done", int'(done_s), 0);
      check("t6_reset_err", int'(err_s), 0);
      step();
      check("t6_no_done", int'(done_s), 0);
      check("t6_idle_busy", int'(busy_s), 0);
      rst_n = 1'b1;
      set_all(5, 5);
      run_op(3'b111);
      check_mat("t6_invalid_keep", 1'b0);
      set_all(1, 2);
      run_op(3'b001);
      set_exp(3);
      check_mat("t6_add_after_err", 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
